// File: rtl/jcsmem_pkg.sv
// Shared mode encoding and display words for jcsmem_explorer.
// MODE_LAST depends on JCSMEM_SCAN_EN.
package jcsmem_pkg;

  typedef enum logic [1:0] {
    MODE_MEM  = 2'd0,
    MODE_REG  = 2'd1,
    MODE_RAM  = 2'd2,
    MODE_SCAN = 2'd3
  } mode_t;

  localparam mode_t MODE_FIRST = MODE_MEM;
`ifdef JCSMEM_SCAN_EN
  localparam mode_t MODE_LAST  = MODE_SCAN;
`else
  localparam mode_t MODE_LAST  = MODE_RAM;
`endif

  localparam logic [31:0] WORD_MEM  = " mem";
  localparam logic [31:0] WORD_REG  = " reg";
  localparam logic [31:0] WORD_RAM  = " ram";
  localparam logic [31:0] WORD_SCAN = "scan";
  localparam logic [31:0] WORD_CLR  = "clr ";

endpackage

// File: rtl/jram_sp.sv
// Single-port synchronous RAM with registered, enable-gated read (read-before-write).
// The read register resets and can be cleared; the array itself is never reset.
module jram_sp #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dout <= '0;
    else if (clr) dout <= '0;
    else if (re)  dout <= mem[addr];
  end

endmodule

// File: rtl/jcsmem_explorer.sv
// Mode FSM over a 1-bit latch, a register and a synchronous RAM, with LED and display outputs.
// Define JCSMEM_SCAN_EN to build the SCAN mode (auto-scan plus hardware clear sweep).
module jcsmem_explorer
  import jcsmem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [AW-1:0]    SW_ADDR,
  input  logic [WIDTH-1:0] SW_DATA,
  input  logic             MODE_PREV,
  input  logic             MODE_NEXT,
  input  logic             SET,
  input  logic             ENA,
  input  logic             TICK,
  output logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED_DATA,
  output logic [AW-1:0]    LED_ADDR,
  output logic             BUSY,
  output logic [31:0]      WORD
);

  mode_t            mode;
  logic             latch;
  logic [WIDTH-1:0] reg_q;
  logic             busy;
  logic [AW-1:0]    scan_addr;
  logic             ram_we, ram_re, ram_clr;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din, ram_dout;

  // PREV has priority; both saturate and are frozen during a sweep
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mode <= MODE_MEM;
    end else if (!busy) begin
      if (MODE_PREV) begin
        if (mode != MODE_FIRST) mode <= mode_t'(mode - 2'd1);
      end else if (MODE_NEXT) begin
        if (mode != MODE_LAST) mode <= mode_t'(mode + 2'd1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      latch <= 1'b0;
      reg_q <= '0;
    end else begin
      if (SET && mode == MODE_MEM) latch <= SW_DATA[0];
      if (SET && mode == MODE_REG) reg_q <= SW_DATA;
    end
  end

`ifdef JCSMEM_SCAN_EN
  logic [AW-1:0] clr_addr;
  logic          tick_d;
  logic          sweep_start;

  assign sweep_start = SET && mode == MODE_SCAN && !busy;

  // tick_d requests the RAM read of the address the TICK just advanced to
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      busy      <= 1'b0;
      clr_addr  <= '0;
      scan_addr <= '0;
      tick_d    <= 1'b0;
    end else begin
      tick_d <= TICK && mode == MODE_SCAN && !busy && !SET;
      if (busy) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == '1) begin
          busy      <= 1'b0;
          scan_addr <= '0;
        end
      end else if (sweep_start) begin
        busy     <= 1'b1;
        clr_addr <= '0;
      end else if (TICK && mode == MODE_SCAN) begin
        scan_addr <= scan_addr + 1'b1;
      end
    end
  end

  assign ram_clr = busy && clr_addr == '1;
`else
  logic unused_tick;
  assign unused_tick = TICK;
  assign busy        = 1'b0;
  assign scan_addr   = '0;
  assign ram_clr     = 1'b0;
`endif

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = SW_ADDR;
    ram_din  = SW_DATA;
`ifdef JCSMEM_SCAN_EN
    if (busy) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
      ram_din  = '0;
    end else if (mode == MODE_SCAN && tick_d) begin
      ram_re   = 1'b1;
      ram_addr = scan_addr;
    end else
`endif
    if (mode == MODE_RAM) begin
      ram_we = SET;
      ram_re = ENA;
    end
  end

  jram_sp #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .rst_n (RESETN),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (ram_clr),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  assign MODE = mode;
  assign BUSY = busy;

  always_comb begin
    case (mode)
      MODE_MEM: LED_DATA = {{(WIDTH-1){1'b0}}, latch};
      MODE_REG: LED_DATA = reg_q;
      default:  LED_DATA = ram_dout;
    endcase
  end

  always_comb begin
    case (mode)
      MODE_RAM:  LED_ADDR = SW_ADDR;
      MODE_SCAN: LED_ADDR = scan_addr;
      default:   LED_ADDR = '0;
    endcase
  end

  always_comb begin
    if (busy) begin
      WORD = WORD_CLR;
    end else begin
      case (mode)
        MODE_MEM: WORD = WORD_MEM;
        MODE_REG: WORD = WORD_REG;
        MODE_RAM: WORD = WORD_RAM;
        default:  WORD = WORD_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_jcsmem_explorer.sv
// Self-checking bench for jcsmem_explorer: directed scenarios plus random pulses vs a behavioural model.
// Follows JCSMEM_SCAN_EN the same way as the design.
module tb_jcsmem_explorer;

  localparam int WIDTH  = 8;
  localparam int AW     = 4;
  localparam int NWORDS = 16;
`ifdef JCSMEM_SCAN_EN
  localparam int LAST_M = 3;
`else
  localparam int LAST_M = 2;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [AW-1:0]    sw_addr = '0;
  logic [WIDTH-1:0] sw_data = '0;
  logic             mode_prev = 1'b0, mode_next = 1'b0, set = 1'b0, ena = 1'b0, tick = 1'b0;
  logic [1:0]       mode_o;
  logic [WIDTH-1:0] led_data;
  logic [AW-1:0]    led_addr;
  logic             busy;
  logic [31:0]      word;

  int n_chk  = 0;
  int n_pass = 0;

  jcsmem_explorer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .CLK       (clk),
    .RESETN    (resetn),
    .SW_ADDR   (sw_addr),
    .SW_DATA   (sw_data),
    .MODE_PREV (mode_prev),
    .MODE_NEXT (mode_next),
    .SET       (set),
    .ENA       (ena),
    .TICK      (tick),
    .MODE      (mode_o),
    .LED_DATA  (led_data),
    .LED_ADDR  (led_addr),
    .BUSY      (busy),
    .WORD      (word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural reference: plain ints and arrays, stepped once per rising edge
  int               m_mode, m_scan, m_busy, m_clr;
  logic             m_latch;
  logic [WIDTH-1:0] m_reg, m_rd;
  bit               m_rd_known, m_pend;
  logic [WIDTH-1:0] m_mem [NWORDS];
  bit               m_known [NWORDS];

  task automatic model_reset();
    m_mode = 0; m_scan = 0; m_busy = 0; m_clr = 0;
    m_latch = 1'b0; m_reg = '0; m_rd = '0; m_rd_known = 1'b1; m_pend = 1'b0;
  endtask

  task automatic model_step();
    bit pend_now;
    pend_now = m_pend;
    m_pend   = 1'b0;
    if (m_busy > 0) begin
      m_mem[m_clr] = '0;
      m_known[m_clr] = 1'b1;
      m_clr++;
      m_busy--;
      if (m_busy == 0) begin
        m_scan = 0; m_rd = '0; m_rd_known = 1'b1;
      end
      return;
    end
    if (pend_now && m_mode == 3) begin
      m_rd = m_mem[m_scan];
      m_rd_known = m_known[m_scan];
    end
    case (m_mode)
      0: if (set) m_latch = sw_data[0];
      1: if (set) m_reg = sw_data;
      2: begin
        if (ena) begin
          m_rd = m_mem[sw_addr];
          m_rd_known = m_known[sw_addr];
        end
        if (set) begin
          m_mem[sw_addr] = sw_data;
          m_known[sw_addr] = 1'b1;
        end
      end
      default: begin
        if (set) begin
          m_busy = NWORDS; m_clr = 0;
        end else if (tick) begin
          m_scan = (m_scan + 1) % NWORDS;
          m_pend = 1'b1;
        end
      end
    endcase
    if (mode_prev)      m_mode = (m_mode > 0) ? m_mode - 1 : 0;
    else if (mode_next) m_mode = (m_mode < LAST_M) ? m_mode + 1 : LAST_M;
  endtask

  function automatic logic [31:0] exp_word();
    if (m_busy > 0) return "clr ";
    case (m_mode)
      0: return " mem";
      1: return " reg";
      2: return " ram";
      default: return "scan";
    endcase
  endfunction

  task automatic check_outputs();
    logic [WIDTH-1:0] e_led;
    logic [AW-1:0]    e_addr;
    bit               led_known;
    e_led = (m_mode == 0) ? {{(WIDTH-1){1'b0}}, m_latch} : (m_mode == 1) ? m_reg : m_rd;
    led_known = (m_mode < 2) || m_rd_known;
    e_addr = (m_mode == 2) ? sw_addr : (m_mode == 3) ? AW'(m_scan) : '0;
    chk("mode", 32'(mode_o), 32'(m_mode));
    chk("busy", 32'(busy), 32'(m_busy > 0));
    chk("word", word, exp_word());
    chk("led_addr", 32'(led_addr), 32'(e_addr));
    if (led_known) chk("led_data", 32'(led_data), 32'(e_led));
  endtask

  task automatic step(input logic p, input logic n, input logic s, input logic e, input logic t,
                      input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    mode_prev = p; mode_next = n; set = s; ena = e; tick = t; sw_addr = a; sw_data = d;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sw_addr, sw_data);
  endtask

  function automatic logic rbit(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  task automatic goto_mode(input int target);
    for (int i = 0; i < 40 && m_busy > 0; i++) idle();
    for (int i = 0; i < 8 && m_mode != target; i++)
      step(1'(target < m_mode), 1'(target > m_mode), 1'b0, 1'b0, 1'b0, sw_addr, sw_data);
    chk("goto_mode", 32'(mode_o), 32'(target));
  endtask

  int busy_cycles;

  initial begin
    for (int i = 0; i < NWORDS; i++) m_known[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    chk("rst_mode", 32'(mode_o), 32'd0);
    chk("rst_led_data", 32'(led_data), 32'd0);
    chk("rst_led_addr", 32'(led_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word", word, " mem");

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("mode_next_sat", 32'(mode_o), 32'((i + 1 < LAST_M) ? i + 1 : LAST_M));
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("prev_wins", 32'(mode_o), 32'(LAST_M - 1));

    goto_mode(0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h01);
    chk("mem_set", 32'(led_data), 32'h01);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 8'hA5);
    chk("reg_set", 32'(led_data), 32'hA5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("mem_kept", 32'(led_data), 32'h01);

    goto_mode(2);
    for (int a = 0; a < NWORDS; a++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, AW'(a), WIDTH'($urandom));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 8'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    chk("ram_read5", 32'(led_data), 32'h3C);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 8'h77);
    chk("ram_rbw_old", 32'(led_data), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    chk("ram_rbw_new", 32'(led_data), 32'h77);

`ifdef JCSMEM_SCAN_EN
    goto_mode(3);
    for (int i = 0; i < NWORDS; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sw_addr, sw_data);
      chk("scan_addr", 32'(led_addr), 32'((i + 1) % NWORDS));
      if (i == 5) chk("scan_data5", 32'(led_data), 32'h77);
      if (i == 6) chk("scan_data6", 32'(led_data), 32'hC3);
    end
    idle();

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sw_addr, sw_data);
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cycles++;
      chk("clr_word", word, "clr ");
      step(1'b0, rbit(2), rbit(3), rbit(3), rbit(2), AW'($urandom), WIDTH'($urandom));
    end
    chk("busy_len", 32'(busy_cycles), 32'd16);
    chk("mode_after_clr", 32'(mode_o), 32'd3);
    chk("addr_after_clr", 32'(led_addr), 32'd0);
    chk("rd_after_clr", 32'(led_data), 32'd0);
    goto_mode(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    chk("ram5_cleared", 32'(led_data), 32'h00);
`endif

    for (int i = 0; i < 1500; i++)
      step(rbit(8), rbit(6), rbit(6), rbit(4), rbit(3), AW'($urandom), WIDTH'($urandom));

`ifdef JCSMEM_SCAN_EN
    goto_mode(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sw_addr, sw_data);
    repeat (7) idle();
    chk("busy_before_rst", 32'(busy), 32'd1);
`else
    goto_mode(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sw_addr, 8'h5A);
`endif
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_mode", 32'(mode_o), 32'd0);
    chk("async_rst_led", 32'(led_data), 32'd0);
    chk("async_rst_word", word, " mem");
    model_reset();
    #1 resetn = 1'b1;
    goto_mode(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
`ifdef JCSMEM_SCAN_EN
    chk("partial_clr0", 32'(led_data), 32'h00);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("final_sat", 32'(mode_o), 32'(LAST_M));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
